// File: rtl/imem_loader_pkg.sv
// Shared constants, state encoding and width helpers for the instruction-memory boot loader.
package imem_loader_pkg;

    localparam logic [7:0] SYNC = 8'hA5;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StCnt,
        StData,
        StWrite,
        StCsum,
        StDone,
        StErr
    } state_e;

    function automatic int unsigned num_bytes(input int unsigned width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Boot-time loader: framed byte stream -> big-endian words on the imem write port.
// Define IMEM_LOADER_CSUM_EN to expect and verify a trailing checksum byte per frame.
`ifndef SIZE_ADDR
`define SIZE_ADDR 16
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 16
`endif

module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = `SIZE_ADDR,
    parameter int unsigned DATA_W = `SIZE_DATA
) (
    input  logic              iw_clk,
    input  logic              iw_rst,
    input  logic [7:0]        iw_rx_data,
    input  logic              iw_rx_valid,
    output logic              ow_rx_ready,
    output logic              ow_mem_we,
    output logic [ADDR_W-1:0] ow_mem_addr,
    output logic [DATA_W-1:0] ow_mem_wdata,
    output logic              ow_core_rst,
    output logic              ow_busy,
    output logic              ow_done,
    output logic              ow_err
);

    localparam int unsigned AB  = num_bytes(ADDR_W);
    localparam int unsigned BPW = num_bytes(DATA_W);
    localparam logic [7:0] AB_LAST  = 8'(AB - 1);
    localparam logic [7:0] BPW_LAST = 8'(BPW - 1);
`ifdef IMEM_LOADER_CSUM_EN
    localparam state_e END_ST = StCsum;
`else
    localparam state_e END_ST = StDone;
`endif

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [7:0]        idx_q, idx_d;
    logic [7:0]        csum_q, csum_d;
    logic              ready_q, ready_d;
    logic              we_q, we_d;
    logic              core_rst_q, core_rst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              acc;
    logic [ADDR_W+7:0] addr_shift;
    logic [DATA_W+7:0] word_shift;
    logic [15:0]       cnt_shift;

    always_comb begin
        acc        = iw_rx_valid && ready_q;
        addr_shift = {addr_q, iw_rx_data};
        word_shift = {word_q, iw_rx_data};
        cnt_shift  = {cnt_q[7:0], iw_rx_data};

        state_d    = state_q;
        addr_d     = addr_q;
        word_d     = word_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        csum_d     = csum_q;
        core_rst_d = core_rst_q;
        done_d     = done_q;
        err_d      = err_q;

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (acc && iw_rx_data == SYNC) begin
                    state_d    = StAddr;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    core_rst_d = 1'b1;
                    csum_d     = 8'h00;
                    idx_d      = 8'h00;
                end
            end
            StAddr: begin
                if (acc) begin
                    addr_d = addr_shift[ADDR_W-1:0];
                    csum_d = csum_q + iw_rx_data;
                    idx_d  = idx_q + 8'd1;
                    if (idx_q == AB_LAST) begin
                        idx_d   = 8'h00;
                        state_d = StCnt;
                    end
                end
            end
            StCnt: begin
                if (acc) begin
                    cnt_d  = cnt_shift;
                    csum_d = csum_q + iw_rx_data;
                    idx_d  = idx_q + 8'd1;
                    if (idx_q == 8'd1) begin
                        idx_d   = 8'h00;
                        state_d = (cnt_shift == 16'd0) ? END_ST : StData;
                    end
                end
            end
            StData: begin
                if (acc) begin
                    word_d = word_shift[DATA_W-1:0];
                    csum_d = csum_q + iw_rx_data;
                    idx_d  = idx_q + 8'd1;
                    if (idx_q == BPW_LAST) begin
                        idx_d   = 8'h00;
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                addr_d  = addr_q + 1'b1;
                cnt_d   = cnt_q - 16'd1;
                state_d = (cnt_q == 16'd1) ? END_ST : StData;
            end
            StCsum: begin
                if (acc) begin
`ifdef IMEM_LOADER_CSUM_EN
                    state_d = (8'(csum_q + iw_rx_data) == 8'h00) ? StDone : StErr;
`else
                    state_d = StDone;
`endif
                end
            end
            default: state_d = StIdle;
        endcase

        // Status flags change on entry to a terminal state only.
        if (state_d == StDone && state_q != StDone) begin
            done_d     = 1'b1;
            core_rst_d = 1'b0;
        end
`ifdef IMEM_LOADER_CSUM_EN
        if (state_d == StErr && state_q != StErr) begin
            err_d = 1'b1;
        end
`else
        err_d = 1'b0;
`endif

        ready_d = (state_d != StWrite);
        we_d    = (state_d == StWrite);
        busy_d  = !(state_d inside {StIdle, StDone, StErr});
    end

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            word_q     <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            csum_q     <= '0;
            ready_q    <= 1'b0;
            we_q       <= 1'b0;
            core_rst_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            word_q     <= word_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            csum_q     <= csum_d;
            ready_q    <= ready_d;
            we_q       <= we_d;
            core_rst_q <= core_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign ow_rx_ready  = ready_q;
    assign ow_mem_we    = we_q;
    assign ow_mem_addr  = addr_q;
    assign ow_mem_wdata = word_q;
    assign ow_core_rst  = core_rst_q;
    assign ow_busy      = busy_q;
    assign ow_done      = done_q;
    assign ow_err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (ADDR_W=16, DATA_W=16); follows IMEM_LOADER_CSUM_EN if defined.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        core_rst;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imem_loader #(
        .ADDR_W(16),
        .DATA_W(16)
    ) dut (
        .iw_clk      (clk),
        .iw_rst      (rst),
        .iw_rx_data  (rx_data),
        .iw_rx_valid (rx_valid),
        .ow_rx_ready (rx_ready),
        .ow_mem_we   (mem_we),
        .ow_mem_addr (mem_addr),
        .ow_mem_wdata(mem_wdata),
        .ow_core_rst (core_rst),
        .ow_busy     (busy),
        .ow_done     (done),
        .ow_err      (err)
    );

    logic [15:0] log_a[$];
    logic [15:0] log_d[$];
    int          hs_viol = 0;

    // ready must be the exact complement of the write strobe outside reset
    always @(negedge clk) begin
        if (!rst && mem_we) begin
            log_a.push_back(mem_addr);
            log_d.push_back(mem_wdata);
        end
        if (!rst && busy && (rx_ready == mem_we)) hs_viol++;
    end

    typedef struct {
        logic [0:11][7:0] b;
        int               len;
        int               nw;
        logic [15:0]      a0, d0, a1, d1;
        logic             exp_done, exp_err, exp_crst;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit gap);
        int guard = 0;
        if (gap) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            errors++;
            $display("FAIL send_timeout: ready stayed 0, byte 0x%0h", b);
        end
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic run_vec(input int i, input bit gap);
        string tag;
        log_a.delete();
        log_d.delete();
        for (int j = 0; j < vecs[i].len; j++) send(vecs[i].b[j], gap);
        repeat (4) @(negedge clk);
        tag = $sformatf("v%0d%s", i, gap ? "g" : "");
        check({tag, "_nwrites"}, log_a.size(), vecs[i].nw);
        if (vecs[i].nw > 0 && log_a.size() > 0) begin
            check({tag, "_a0"}, log_a[0], vecs[i].a0);
            check({tag, "_d0"}, log_d[0], vecs[i].d0);
        end
        if (vecs[i].nw > 1 && log_a.size() > 1) begin
            check({tag, "_a1"}, log_a[1], vecs[i].a1);
            check({tag, "_d1"}, log_d[1], vecs[i].d1);
        end
        check({tag, "_done"}, done, vecs[i].exp_done);
        check({tag, "_err"}, err, vecs[i].exp_err);
        check({tag, "_crst"}, core_rst, vecs[i].exp_crst);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        vecs[0] = '{b: {8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDA,
                        8'h00, 8'h00},
                    len: 10, nw: 2, a0: 16'h0010, d0: 16'h1234, a1: 16'h0011, d1: 16'h5678,
                    exp_done: 1'b1, exp_err: 1'b0, exp_crst: 1'b0};
`ifdef IMEM_LOADER_CSUM_EN
        vecs[1] = '{b: {8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDB,
                        8'h00, 8'h00},
                    len: 10, nw: 2, a0: 16'h0010, d0: 16'h1234, a1: 16'h0011, d1: 16'h5678,
                    exp_done: 1'b0, exp_err: 1'b1, exp_crst: 1'b1};
`else
        // Without checksum the trailing byte lands in DONE and is discarded.
        vecs[1] = '{b: {8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDB,
                        8'h00, 8'h00},
                    len: 10, nw: 2, a0: 16'h0010, d0: 16'h1234, a1: 16'h0011, d1: 16'h5678,
                    exp_done: 1'b1, exp_err: 1'b0, exp_crst: 1'b0};
`endif
        vecs[2] = '{b: {8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hF2,
                        8'h00, 8'h00},
                    len: 10, nw: 2, a0: 16'hFFFF, d0: 16'hAABB, a1: 16'h0000, d1: 16'hCCDD,
                    exp_done: 1'b1, exp_err: 1'b0, exp_crst: 1'b0};
        vecs[3] = '{b: {8'h11, 8'h22, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                        8'h00, 8'h00},
                    len: 8, nw: 0, a0: 16'h0, d0: 16'h0, a1: 16'h0, d1: 16'h0,
                    exp_done: 1'b1, exp_err: 1'b0, exp_crst: 1'b0};

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_ready", rx_ready, 1'b0);
        check("rst_crst", core_rst, 1'b1);
        check("rst_we", mem_we, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_ready", rx_ready, 1'b1);
        check("idle_crst", core_rst, 1'b1);

        for (int i = 0; i < 4; i++) run_vec(i, 1'b0);

        // Write latency and release timing
        log_a.delete();
        log_d.delete();
        send(8'hA5, 1'b0);
        send(8'h00, 1'b0);
        send(8'h20, 1'b0);
        check("lat_busy", busy, 1'b1);
        check("lat_crst_held", core_rst, 1'b1);
        send(8'h00, 1'b0);
        send(8'h01, 1'b0);
        send(8'h9A, 1'b0);
        send(8'hBC, 1'b0);
        @(negedge clk);
        check("lat_we", mem_we, 1'b1);
        check("lat_ready_low", rx_ready, 1'b0);
        check("lat_addr", mem_addr, 16'h0020);
        check("lat_wdata", mem_wdata, 16'h9ABC);
`ifdef IMEM_LOADER_CSUM_EN
        send(8'h89, 1'b0);
        @(negedge clk);
`else
        @(negedge clk);
`endif
        check("rel_we_low", mem_we, 1'b0);
        check("rel_done", done, 1'b1);
        check("rel_crst", core_rst, 1'b0);

        // Reset in the middle of the second word
        log_a.delete();
        log_d.delete();
        send(8'hA5, 1'b0);
        send(8'h00, 1'b0);
        send(8'h40, 1'b0);
        send(8'h00, 1'b0);
        send(8'h03, 1'b0);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_nwrites", log_a.size(), 1);
        check("mid_crst", core_rst, 1'b1);
        check("mid_busy", busy, 1'b0);
        check("mid_done", done, 1'b0);
        check("mid_ready", rx_ready, 1'b1);
        run_vec(0, 1'b0);

        // Valid toggled every other cycle
        hs_viol = 0;
        run_vec(0, 1'b1);
        check("gap_handshake", hs_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
